// File: rtl/ucode_issue_arbiter.sv
// ucode_issue_arbiter
// Owns the single instruction slot between IF and decode/issue. Plain
// instructions pass straight through. A MUL is swallowed and replaced by the
// micro-op stream from the microcode sequencer. A watchdog aborts the
// sequence if the sequencer goes silent for too long.
module ucode_issue_arbiter #(
  parameter logic [5:0]  MUL_OPCODE  = 6'b011100,
  parameter logic [31:0] NOP_INSTR   = 32'hC800_0000,
  parameter int          STALL_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  // sequencer side
  output logic        seq_start,
  output logic [3:0]  seq_dest,
  output logic [3:0]  seq_src,
  output logic [15:0] seq_imm,
  input  logic        seq_valid,
  input  logic [31:0] seq_instr,
  input  logic        seq_last,
  output logic        seq_advance,
  output logic        seq_abort,
  // pipeline side
  output logic        out_valid,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  // status
  output logic        busy,
  output logic        err_stall,
  output logic [15:0] mul_count,
  output logic [15:0] uop_count
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state;
  logic [STALL_W-1:0] stall_cnt;

  logic is_mul;
  logic accept_mul;
  logic advance;
  logic stall_hit;

  assign is_mul     = (if_instr[31:26] == MUL_OPCODE);
  assign accept_mul = (state == PASS) && if_valid && is_mul;
  assign advance    = (state == RUN) && seq_valid && out_ready;
  // The current cycle is the STALL_LIMIT-th consecutive silent cycle.
  assign stall_hit  = (state == RUN) && !seq_valid &&
                      (stall_cnt == STALL_W'(STALL_LIMIT - 1));

  assign busy = (state != PASS);

  // Slot steering: outputs are a function of state and this cycle's inputs,
  // forced to their idle values while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    if_ready    = 1'b0;
    out_valid   = 1'b0;
    out_instr   = NOP_INSTR;
    seq_start   = 1'b0;
    seq_advance = 1'b0;
    seq_abort   = 1'b0;
    if (!rst) begin
      unique case (state)
        PASS: begin
          if (accept_mul) begin
            // Consume the MUL even if the pipeline is backpressured; it never
            // reaches the pipeline itself.
            if_ready = 1'b1;
          end else begin
            if_ready  = out_ready;
            out_valid = if_valid;
            out_instr = if_valid ? if_instr : NOP_INSTR;
          end
        end
        START: begin
          seq_start = 1'b1;
        end
        RUN: begin
          out_valid   = seq_valid;
          out_instr   = seq_valid ? seq_instr : NOP_INSTR;
          seq_advance = advance;
          seq_abort   = stall_hit;
        end
        default: ;
      endcase
    end
  end

  // Sequencing state, latched MUL operands, watchdog and counters.
  // NOTE: reset is asynchronous and active-high so the slot is released the
  // instant rst rises, even without a running clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PASS;
      stall_cnt <= '0;
      seq_dest  <= '0;
      seq_src   <= '0;
      seq_imm   <= '0;
      err_stall <= 1'b0;
      mul_count <= '0;
      uop_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      unique case (state)
        PASS: begin
          if (accept_mul) begin
            seq_dest  <= if_instr[25:22];
            seq_src   <= if_instr[21:18];
            seq_imm   <= if_instr[15:0];
            uop_count <= '0;
            state     <= START;
          end
        end
        START: begin
          stall_cnt <= '0;
          state     <= RUN;
        end
        RUN: begin
          // Backpressure is not a sequencer stall: any valid micro-op resets
          // the watchdog.
          if (seq_valid) stall_cnt <= '0;
          else           stall_cnt <= stall_cnt + STALL_W'(1);

          if (advance) begin
            if (uop_count != 16'hFFFF) uop_count <= uop_count + 16'd1;
            if (seq_last) begin
              mul_count <= mul_count + 16'd1;
              state     <= PASS;
            end
          end else if (stall_hit) begin
            err_stall <= 1'b1;
            state     <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: doc/ucode_issue_arbiter.md
Name: ucode_issue_arbiter

Overview:
- Sits between the IF stage and the decode/issue pipeline, and owns the pipeline's single instruction slot.
- Passes fetched instructions through unchanged. When it sees a MUL, it consumes that instruction, starts the microcode sequencer, and forwards the sequencer's MOV/ADD/SUB micro-ops with ready/valid flow control until the last micro-op, then returns the slot to fetch.
- Adds a stall watchdog, an abort path and performance counters.

Parameters:
- MUL_OPCODE, 6'b011100: value of instr[31:26] that identifies MUL.
- NOP_INSTR, 32'hC800_0000: instruction driven when out_valid is 0 (this is {5'b11001, 27'b0}).
- STALL_LIMIT, 64: maximum consecutive RUN cycles with seq_valid low before an abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  fetched instruction valid
- if_instr  in  32  fetched instruction
- if_ready  out  1  arbiter accepts if_instr this cycle
- seq_start  out  1  one-cycle start pulse to the sequencer
- seq_dest  out  4  latched MUL destination register, instr[25:22]
- seq_src  out  4  latched MUL source register, instr[21:18]
- seq_imm  out  16  latched MUL immediate, instr[15:0]
- seq_valid  in  1  sequencer micro-op valid
- seq_instr  in  32  sequencer micro-op
- seq_last  in  1  current micro-op is the final one
- seq_advance  out  1  micro-op consumed; the sequencer steps on this
- seq_abort  out  1  one-cycle pulse; the sequencer returns to idle
- out_valid  out  1  instruction to pipeline valid
- out_instr  out  32  instruction to pipeline
- out_ready  in  1  pipeline can accept
- busy  out  1  state != PASS
- err_stall  out  1  sticky watchdog error
- mul_count  out  16  MULs completed normally; wraps at 16'hFFFF
- uop_count  out  16  micro-ops issued in the current or last MUL

Behaviour:
- Reset:
  - state=PASS; latched fields, counters and err_stall cleared.
  - While rst is high: if_ready=0, out_valid=0, out_instr=NOP_INSTR, seq_start=0, seq_advance=0, seq_abort=0.
  - Reset mid-sequence discards the in-flight MUL; no pulse is emitted.
- States: PASS, START, RUN. Outputs are combinational from state and inputs. State, latched fields and counters are registered.
- PASS, instruction is not a MUL (if_instr[31:26] != MUL_OPCODE):
  - out_valid=if_valid, out_instr=if_instr, if_ready=out_ready. Zero-latency pass-through.
- PASS, if_valid=1 and instruction is a MUL:
  - if_ready=1 regardless of out_ready; out_valid=0, out_instr=NOP_INSTR.
  - Latch dest/src/imm, clear uop_count, next state START.
- START:
  - seq_start=1 for exactly one cycle; if_ready=0, out_valid=0.
  - Clear the stall counter; next state RUN.
- RUN:
  - out_valid=seq_valid, out_instr=seq_valid ? seq_instr : NOP_INSTR, if_ready=0.
  - seq_advance = seq_valid & out_ready.
  - On each advance: uop_count += 1, saturating at 16'hFFFF.
  - Advance with seq_last=1: mul_count += 1, next state PASS. The next fetched instruction can be accepted the following cycle.
  - seq_valid=0: the stall counter increments. seq_valid=1 clears it, including when out_ready=0, since backpressure is not a sequencer stall.
  - Stall counter reaches STALL_LIMIT: seq_abort=1 that cycle, err_stall set, next state PASS, mul_count unchanged.
  - Advance-with-last and the limit in the same cycle: the last micro-op wins; no abort, no error.
- out_ready=0 in RUN: the micro-op is held (out_instr stable), seq_advance=0, no counting.
- seq_last without seq_valid is ignored.
- seq_valid in PASS or START is ignored: seq_advance=0.
- seq_dest, seq_src and seq_imm hold their values until the next MUL is accepted.
- The imm=0 case (single SUB with last) and the imm=1 case need no special handling in the arbiter.

Test Plan:
- Non-MUL stream 0x1234_5678, 0x0ABC_0001, out_ready=1 -> out_instr equals if_instr in the same cycle, busy=0, seq_start never asserts.
- MUL R1,R0,#3 (instr[31:26]=MUL_OPCODE, dest=1, src=0, imm=3) -> if_ready=1 that cycle; seq_start the next cycle with seq_dest=1, seq_src=0, seq_imm=3. Sequencer model yields MOV+3 ADD, last on the 4th -> 4 out_valid beats, uop_count=4, mul_count=1, PASS afterwards.
- Same MUL with out_ready toggling 1,0,0,1 -> each micro-op held stable while stalled; exactly 4 advances; no err_stall.
- MUL #0, sequencer returns one SUB with seq_last -> single beat, uop_count=1, mul_count=1.
- Sequencer holds seq_valid=0 in RUN -> seq_abort on the 64th stall cycle, err_stall=1, mul_count unchanged, next non-MUL passes through.
- Assert rst during RUN after 2 micro-ops -> outputs immediately at reset values, uop_count=0, first instruction after release passes through.
